// File: rtl/dmem_stage.sv
// Memory-stage load/store unit with byte-lane RAM and optional wait-state stall.
// Optional feature: define DMEM_MISALIGN_TRAP_EN to flag misaligned half/word accesses instead of forcing alignment.
module dmem_stage #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memWrtm,
    input  logic        memRdm,
    input  logic [2:0]  funct3m,
    input  logic [31:0] aluRsltm,
    input  logic [31:0] wrtDatam,
    output logic [31:0] readDm,
    output logic        stallm,
    output logic        misalignm
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic [31:0] mem [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic          req, illegal, misal, bad, access, complete, we;
    logic [3:0]    be;
    logic [31:0]   wdata, rword, ext;
    logic [7:0]    bsel;
    logic [15:0]   hsel;
    logic          unused_hi;

    assign idx       = aluRsltm[AW+1:2];
    assign unused_hi = ^aluRsltm[31:AW+2];

    always_comb begin
        req     = memWrtm | memRdm;
        illegal = (funct3m == 3'b011) || (funct3m[2:1] == 2'b11);
`ifdef DMEM_MISALIGN_TRAP_EN
        misal   = ((funct3m[1:0] == 2'b01) && aluRsltm[0]) ||
                  ((funct3m == 3'b010) && (aluRsltm[1:0] != 2'b00));
`else
        misal   = 1'b0;
`endif
        bad     = illegal | misal;
        access  = req & ~bad;
    end

    // complete marks the one cycle in which load data is valid and a store commits
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        complete  = 1'b0;
        stallm    = 1'b0;
        if (WAIT_STATES == 0) begin
            complete = access;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        stallm    = 1'b1;
                        state_nxt = BUSY;
                        cnt_nxt   = 8'(WAIT_STATES - 1);
                    end
                end
                BUSY: begin
                    if (!access) begin
                        state_nxt = IDLE;
                    end else if (cnt != 8'd0) begin
                        stallm  = 1'b1;
                        cnt_nxt = cnt - 8'd1;
                    end else begin
                        complete  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
        if (rst) begin
            stallm   = 1'b0;
            complete = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // store data is replicated across lanes; be picks which lanes land
    always_comb begin
        case (funct3m[1:0])
            2'b00: begin
                be    = 4'b0001 << aluRsltm[1:0];
                wdata = {4{wrtDatam[7:0]}};
            end
            2'b01: begin
                be    = aluRsltm[1] ? 4'b1100 : 4'b0011;
                wdata = {2{wrtDatam[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = wrtDatam;
            end
        endcase
        we = complete & memWrtm;
    end

    always_ff @(posedge clk) begin
        if (we) begin
            for (int l = 0; l < 4; l++) begin
                if (be[l]) mem[idx][8*l +: 8] <= wdata[8*l +: 8];
            end
        end
    end

    always_comb begin
        rword = mem[idx];
        bsel  = 8'(rword >> {aluRsltm[1:0], 3'b000});
        hsel  = aluRsltm[1] ? rword[31:16] : rword[15:0];
        case (funct3m)
            3'b000:  ext = {{24{bsel[7]}}, bsel};
            3'b100:  ext = {24'd0, bsel};
            3'b001:  ext = {{16{hsel[15]}}, hsel};
            3'b101:  ext = {16'd0, hsel};
            default: ext = rword;
        endcase
        readDm    = (complete && memRdm && !memWrtm) ? ext : 32'd0;
        misalignm = req & bad & ~rst;
    end
endmodule

// File: tb/tb_dmem_stage.sv
// Bench for dmem_stage: zero-wait and three-wait-state instances share stimulus,
// each checked against its own behavioural memory model.
module tb_dmem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        memWrtm, memRdm;
    logic [2:0]  funct3m;
    logic [31:0] aluRsltm, wrtDatam;
    logic [31:0] rd0, rd3;
    logic        st0, st3, ma0, ma3;

    int checks = 0;
    int failures = 0;
    logic [31:0] m0 [1024];
    logic [31:0] m3 [1024];
    logic [31:0] last0, last3;

    always #5 clk = ~clk;

    dmem_stage #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u0 (
        .clk(clk), .rst(rst), .memWrtm(memWrtm), .memRdm(memRdm), .funct3m(funct3m),
        .aluRsltm(aluRsltm), .wrtDatam(wrtDatam), .readDm(rd0), .stallm(st0), .misalignm(ma0));

    dmem_stage #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u3 (
        .clk(clk), .rst(rst), .memWrtm(memWrtm), .memRdm(memRdm), .funct3m(funct3m),
        .aluRsltm(aluRsltm), .wrtDatam(wrtDatam), .readDm(rd3), .stallm(st3), .misalignm(ma3));

    function automatic logic is_bad(input logic [2:0] f3, input logic [31:0] a);
        logic b;
        b = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) b = 1'b1;
        if (f3 == 3'd2 && (a % 4 != 0)) b = 1'b1;
`endif
        return b;
    endfunction

    function automatic logic [31:0] ref_ld(input logic [31:0] w, input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] b, h;
        b = (w >> (8 * (a % 4))) & 32'hFF;
        h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b - 32'd256 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_st(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [31:0] a, input logic [31:0] d);
        logic [31:0] m, v;
        case (f3 % 4)
            0: begin m = 32'hFF << (8 * (a % 4)); v = (d & 32'hFF) << (8 * (a % 4)); end
            1: begin m = 32'hFFFF << (16 * ((a / 2) % 2)); v = (d & 32'hFFFF) << (16 * ((a / 2) % 2)); end
            default: begin m = 32'hFFFF_FFFF; v = d; end
        endcase
        return (w & ~m) | (v & m);
    endfunction

    // One request held for four cycles (the three-wait-state latency); both DUTs checked each cycle.
    task automatic run_access(input logic wr, input logic rd, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] d, input string nm);
        int w;
        logic bad, acc, mis;
        logic [31:0] e0, e3, x3;
        w   = int'((a >> 2) % 1024);
        bad = is_bad(f3, a);
        mis = (wr | rd) & bad;
        acc = (wr | rd) & !bad;
        e0  = (rd && !wr && acc) ? ref_ld(m0[w], f3, a) : 32'd0;
        e3  = (rd && !wr && acc) ? ref_ld(m3[w], f3, a) : 32'd0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            memWrtm = wr; memRdm = rd; funct3m = f3; aluRsltm = a; wrtDatam = d;
            #1;
            x3 = (c == 3) ? e3 : 32'd0;
            checks += 6;
            if (st0 !== 1'b0) begin failures++; $display("FAIL %s ws0 stall c%0d got=%b exp=0", nm, c, st0); end
            if (rd0 !== e0) begin failures++; $display("FAIL %s ws0 readDm c%0d got=%h exp=%h", nm, c, rd0, e0); end
            if (ma0 !== mis) begin failures++; $display("FAIL %s ws0 misalign c%0d got=%b exp=%b", nm, c, ma0, mis); end
            if (st3 !== (acc && c < 3)) begin failures++; $display("FAIL %s ws3 stall c%0d got=%b exp=%b", nm, c, st3, acc && c < 3); end
            if (rd3 !== x3) begin failures++; $display("FAIL %s ws3 readDm c%0d got=%h exp=%h", nm, c, rd3, x3); end
            if (ma3 !== mis) begin failures++; $display("FAIL %s ws3 misalign c%0d got=%b exp=%b", nm, c, ma3, mis); end
            last0 = rd0;
            last3 = rd3;
        end
        if (wr && acc) begin
            m0[w] = ref_st(m0[w], f3, a, d);
            m3[w] = ref_st(m3[w], f3, a, d);
        end
    endtask

    task automatic idle_inputs();
        memWrtm = 1'b0; memRdm = 1'b0; funct3m = 3'd2; aluRsltm = 32'd0; wrtDatam = 32'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        memWrtm = 1'b0; memRdm = 1'b1; funct3m = 3'b011; aluRsltm = 32'h10; wrtDatam = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks += 4;
        if (st0 !== 1'b0 || st3 !== 1'b0) begin failures++; $display("FAIL reset stall got=%b%b exp=00", st0, st3); end
        if (ma0 !== 1'b0 || ma3 !== 1'b0) begin failures++; $display("FAIL reset misalign got=%b%b exp=00", ma0, ma3); end
        if (rd0 !== 32'd0) begin failures++; $display("FAIL reset ws0 readDm got=%h exp=0", rd0); end
        if (rd3 !== 32'd0) begin failures++; $display("FAIL reset ws3 readDm got=%h exp=0", rd3); end
        idle_inputs();
        rst = 1'b0;
    endtask

    task automatic test_prefill();
        for (int i = 0; i < 16; i++)
            run_access(1'b1, 1'b0, 3'd2, 32'(i * 4), $urandom, "prefill");
    endtask

    task automatic test_plan_loads();
        run_access(1'b1, 1'b0, 3'd2, 32'h10, 32'hDEADBEEF, "sw_10");
        run_access(1'b0, 1'b1, 3'd2, 32'h10, 32'd0, "lw_10");
        checks++;
        if (last3 !== 32'hDEADBEEF) begin failures++; $display("FAIL plan lw got=%h exp=deadbeef", last3); end
        run_access(1'b0, 1'b1, 3'd0, 32'h13, 32'd0, "lb_13");
        checks++;
        if (last3 !== 32'hFFFFFFDE) begin failures++; $display("FAIL plan lb got=%h exp=ffffffde", last3); end
        run_access(1'b0, 1'b1, 3'd4, 32'h13, 32'd0, "lbu_13");
        checks++;
        if (last0 !== 32'h000000DE) begin failures++; $display("FAIL plan lbu got=%h exp=000000de", last0); end
        run_access(1'b0, 1'b1, 3'd1, 32'h12, 32'd0, "lh_12");
        checks++;
        if (last3 !== 32'hFFFFDEAD) begin failures++; $display("FAIL plan lh got=%h exp=ffffdead", last3); end
        run_access(1'b0, 1'b1, 3'd5, 32'h10, 32'd0, "lhu_10");
        checks++;
        if (last3 !== 32'h0000BEEF) begin failures++; $display("FAIL plan lhu got=%h exp=0000beef", last3); end
        run_access(1'b0, 1'b1, 3'd2, 32'h1010, 32'd0, "lw_wrap");
        checks++;
        if (last3 !== 32'hDEADBEEF) begin failures++; $display("FAIL plan wrap got=%h exp=deadbeef", last3); end
    endtask

    task automatic test_back_to_back();
        run_access(1'b1, 1'b0, 3'd0, 32'h11, 32'h12345677, "sb_11");
        run_access(1'b0, 1'b1, 3'd2, 32'h10, 32'd0, "lw_after_sb");
        checks++;
        if (last3 !== 32'hDEAD77EF) begin failures++; $display("FAIL plan sb got=%h exp=dead77ef", last3); end
        run_access(1'b1, 1'b1, 3'd2, 32'h14, 32'hCAFEF00D, "both_high");
        run_access(1'b0, 1'b1, 3'd2, 32'h14, 32'd0, "lw_both");
        checks++;
        if (last0 !== 32'hCAFEF00D) begin failures++; $display("FAIL both-high store got=%h exp=cafef00d", last0); end
    endtask

    task automatic test_reset_busy();
        logic [31:0] old3;
        old3 = m3[8];
        @(negedge clk);
        memWrtm = 1'b1; memRdm = 1'b0; funct3m = 3'd2; aluRsltm = 32'h20; wrtDatam = 32'hA5A5A5A5;
        #1;
        checks++;
        if (st3 !== 1'b1) begin failures++; $display("FAIL rstbusy first stall got=%b exp=1", st3); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (st3 !== 1'b0 || st0 !== 1'b0) begin failures++; $display("FAIL rstbusy stall in rst got=%b%b exp=00", st0, st3); end
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        #1;
        checks++;
        if (st3 !== 1'b0) begin failures++; $display("FAIL rstbusy stall after got=%b exp=0", st3); end
        m0[8] = 32'hA5A5A5A5;
        run_access(1'b0, 1'b1, 3'd2, 32'h20, 32'd0, "lw_after_rst");
        checks++;
        if (last3 !== old3) begin failures++; $display("FAIL rstbusy old value got=%h exp=%h", last3, old3); end
    endtask

    task automatic test_flush();
        @(negedge clk);
        memWrtm = 1'b1; memRdm = 1'b0; funct3m = 3'd2; aluRsltm = 32'h24; wrtDatam = 32'h11223344;
        #1;
        checks++;
        if (st3 !== 1'b1) begin failures++; $display("FAIL flush stall c0 got=%b exp=1", st3); end
        @(negedge clk); #1;
        checks++;
        if (st3 !== 1'b1) begin failures++; $display("FAIL flush stall c1 got=%b exp=1", st3); end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (st3 !== 1'b0) begin failures++; $display("FAIL flush stall drop got=%b exp=0", st3); end
        m0[9] = 32'h11223344;
        run_access(1'b0, 1'b1, 3'd2, 32'h24, 32'd0, "lw_after_flush");
    endtask

    task automatic test_misalign();
        run_access(1'b1, 1'b0, 3'd1, 32'h21, 32'h0000BEAD, "sh_21");
        run_access(1'b0, 1'b1, 3'd2, 32'h20, 32'd0, "lw_after_sh");
        run_access(1'b0, 1'b1, 3'b011, 32'h20, 32'd0, "illegal_011");
        checks++;
        if (ma0 !== 1'b1) begin failures++; $display("FAIL illegal misalign got=%b exp=1", ma0); end
        run_access(1'b1, 1'b0, 3'b111, 32'h20, 32'hFFFFFFFF, "illegal_st");
        run_access(1'b0, 1'b1, 3'd2, 32'h22, 32'd0, "lw_22");
    endtask

    task automatic test_random();
        logic [2:0] f3s [8];
        f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3, 3'd6};
        for (int i = 0; i < 60; i++) begin
            int k;
            logic wr, rd;
            k  = int'($urandom % 8);
            wr = (k == 1) || (k >= 2 && k <= 4);
            rd = (k == 1) || (k >= 5);
            run_access(wr, rd, f3s[$urandom % 8], 32'($urandom_range(0, 63)), $urandom, "random");
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_prefill();
        test_plan_loads();
        test_back_to_back();
        test_reset_busy();
        test_flush();
        test_misalign();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
